stq_drain_ctrl: RTL and testbench

STQ_DRAIN_CTRL -- requirements
Module: stq_drain_ctrl

---
 rtl/stq_drain_ctrl_pkg.sv | 27 ++
 rtl/stq_ptr_ctrl.sv | 54 +++++
 rtl/stq_drain_ctrl.sv | 103 ++++++++++
 tb/tb_stq_drain_ctrl.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/stq_drain_ctrl_pkg.sv
// Shared LSU types for the store-queue drain path: entry layout, access size
// encoding and the drain FSM state enum.
package stq_drain_ctrl_pkg;

  localparam int STQ_ADDR_W = 32;
  localparam int STQ_DATA_W = 64;

  typedef enum logic [1:0] {
    SZ_BYTE  = 2'd0,
    SZ_HALF  = 2'd1,
    SZ_WORD  = 2'd2,
    SZ_DWORD = 2'd3
  } stq_size_e;

  // RAM word layout, MSB first: {addr, data, size}
  typedef struct packed {
    logic [STQ_ADDR_W-1:0] addr;
    logic [STQ_DATA_W-1:0] data;
    stq_size_e             size;
  } stq_entry_t;

  typedef enum logic {
    DRN_IDLE = 1'b0,
    DRN_SEND = 1'b1
  } drain_state_e;

endpackage

// File: rtl/stq_ptr_ctrl.sv
// Store-queue head/tail pointers plus occupancy and committed-entry counters,
// including flush recovery of the tail to just past the last committed store.
module stq_ptr_ctrl #(
  parameter int DEPTH = 16,
  parameter int INDEX = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             alloc,
  input  logic             commit,
  input  logic             flush,
  input  logic             drain,
  output logic [INDEX-1:0] head,
  output logic [INDEX-1:0] tail,
  output logic [INDEX:0]   count,
  output logic [INDEX:0]   commit_cnt,
  output logic             commit_ok
);

  localparam logic [INDEX:0] FULL_CNT = (INDEX+1)'(DEPTH);

  logic             alloc_ok;
  logic [INDEX-1:0] head_nxt;
  logic [INDEX:0]   ccnt_nxt;

  assign commit_ok = commit && (commit_cnt < count);
  assign alloc_ok  = alloc && (count != FULL_CNT) && !flush;

  always_comb begin
    head_nxt = head + INDEX'(drain);
    ccnt_nxt = commit_cnt + (INDEX+1)'(commit_ok) - (INDEX+1)'(drain);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      commit_cnt <= '0;
    end else begin
      head       <= head_nxt;
      commit_cnt <= ccnt_nxt;
      if (flush) begin
        // Tail rebased on the post-drain head; modulo wrap is intentional.
        tail  <= head_nxt + ccnt_nxt[INDEX-1:0];
        count <= ccnt_nxt;
      end else begin
        tail  <= tail + INDEX'(alloc_ok);
        count <= count + (INDEX+1)'(alloc_ok) - (INDEX+1)'(drain);
      end
    end
  end

endmodule

// File: rtl/stq_drain_ctrl.sv
// Store-queue drain controller: sends committed stores from the STQ head to
// the D-cache one at a time with a registered valid/ready request.
module stq_drain_ctrl
  import stq_drain_ctrl_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int INDEX  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     alloc_i,
  output logic [INDEX-1:0]         allocIdx_o,
  input  logic                     commitSt_i,
  input  logic                     flush_i,
  output logic [INDEX-1:0]         stqRdAddr_o,
  input  logic [ADDR_W+DATA_W+1:0] stqRdData_i,
  output logic                     dcWrValid_o,
  input  logic                     dcWrReady_i,
  output logic [ADDR_W-1:0]        dcWrAddr_o,
  output logic [DATA_W-1:0]        dcWrData_o,
  output logic [1:0]               dcWrSize_o,
  output logic                     stqFull_o,
  output logic                     stqEmpty_o,
  output logic [INDEX:0]           stqCount_o,
  output logic [INDEX:0]           commitCnt_o
);

  drain_state_e     state_q, state_d;
  logic             capture, drain, commit_ok;
  logic [INDEX-1:0] head, tail;
  logic [INDEX:0]   count, commit_cnt;
  logic [ADDR_W-1:0] pl_addr;
  logic [DATA_W-1:0] pl_data;
  stq_size_e         pl_size;

  stq_ptr_ctrl #(.DEPTH(DEPTH), .INDEX(INDEX)) u_ptr (
    .clk        (clk),
    .reset      (reset),
    .alloc      (alloc_i),
    .commit     (commitSt_i),
    .flush      (flush_i),
    .drain      (drain),
    .head       (head),
    .tail       (tail),
    .count      (count),
    .commit_cnt (commit_cnt),
    .commit_ok  (commit_ok)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= DRN_IDLE;
    else       state_q <= state_d;
  end

  // A same-cycle commit also qualifies, giving one-cycle commit-to-valid.
  always_comb begin
    state_d     = state_q;
    capture     = 1'b0;
    drain       = 1'b0;
    dcWrValid_o = 1'b0;
    case (state_q)
      DRN_IDLE: begin
        if ((commit_cnt != '0) || commit_ok) begin
          capture = 1'b1;
          state_d = DRN_SEND;
        end
      end
      DRN_SEND: begin
        dcWrValid_o = 1'b1;
        if (dcWrReady_i) begin
          drain   = 1'b1;
          state_d = DRN_IDLE;
        end
      end
      default: state_d = DRN_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pl_addr <= '0;
      pl_data <= '0;
      pl_size <= SZ_BYTE;
    end else if (capture) begin
      pl_addr <= stqRdData_i[ADDR_W+DATA_W+1 -: ADDR_W];
      pl_data <= stqRdData_i[DATA_W+1 -: DATA_W];
      pl_size <= stq_size_e'(stqRdData_i[1:0]);
    end
  end

  assign dcWrAddr_o  = pl_addr;
  assign dcWrData_o  = pl_data;
  assign dcWrSize_o  = pl_size;
  assign allocIdx_o  = tail;
  assign stqRdAddr_o = head;
  assign stqCount_o  = count;
  assign commitCnt_o = commit_cnt;
  assign stqFull_o   = (count == (INDEX+1)'(DEPTH));
  assign stqEmpty_o  = (count == '0);

endmodule

// File: tb/tb_stq_drain_ctrl.sv
// Randomized bench for stq_drain_ctrl against a queue-level reference model.
module tb_stq_drain_ctrl;

  localparam int DEPTH = 16, INDEX = 4, ADDR_W = 32, DATA_W = 64;
  localparam int EW = ADDR_W + DATA_W + 2;

  logic clk = 1'b0, reset = 1'b1;
  logic alloc_i = 0, commitSt_i = 0, flush_i = 0, dcWrReady_i = 0;
  logic [INDEX-1:0]  allocIdx_o, stqRdAddr_o;
  logic [EW-1:0]     stqRdData_i;
  logic              dcWrValid_o, stqFull_o, stqEmpty_o;
  logic [ADDR_W-1:0] dcWrAddr_o;
  logic [DATA_W-1:0] dcWrData_o;
  logic [1:0]        dcWrSize_o;
  logic [INDEX:0]    stqCount_o, commitCnt_o;

  logic [EW-1:0] mem [DEPTH];
  assign stqRdData_i = mem[stqRdAddr_o];

  always #5 clk = ~clk;

  stq_drain_ctrl #(.DEPTH(DEPTH), .INDEX(INDEX), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset), .alloc_i(alloc_i), .allocIdx_o(allocIdx_o),
    .commitSt_i(commitSt_i), .flush_i(flush_i), .stqRdAddr_o(stqRdAddr_o),
    .stqRdData_i(stqRdData_i), .dcWrValid_o(dcWrValid_o), .dcWrReady_i(dcWrReady_i),
    .dcWrAddr_o(dcWrAddr_o), .dcWrData_o(dcWrData_o), .dcWrSize_o(dcWrSize_o),
    .stqFull_o(stqFull_o), .stqEmpty_o(stqEmpty_o), .stqCount_o(stqCount_o),
    .commitCnt_o(commitCnt_o)
  );

  int checks = 0, failures = 0;
  int sends = 0;

  // Reference model: queue positions, occupancy, committed count, and one
  // outstanding D-cache request with its expected payload.
  int m_head, m_tail, m_cnt, m_ccnt;
  bit m_busy;
  logic [EW-1:0] m_pl;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [EW-1:0] rand_entry();
    return {$urandom(), $urandom(), $urandom(), 2'($urandom_range(0, 3))};
  endfunction

  task automatic model_clear();
    m_head = 0; m_tail = 0; m_cnt = 0; m_ccnt = 0; m_busy = 0; m_pl = '0;
  endtask

  task automatic cyc(input bit rs, input bit a, input bit c, input bit f, input bit r);
    int nh, nt, nc, ncc, wr_idx;
    bit drained, cok, aok, nbusy;
    logic [EW-1:0] npl;
    @(negedge clk);
    reset = rs; alloc_i = a; commitSt_i = c; flush_i = f; dcWrReady_i = r;
    #1;
    chk("allocIdx", 128'(allocIdx_o), 128'(m_tail));
    chk("rdAddr",   128'(stqRdAddr_o), 128'(m_head));
    chk("count",    128'(stqCount_o), 128'(m_cnt));
    chk("commitCnt",128'(commitCnt_o), 128'(m_ccnt));
    chk("full",     128'(stqFull_o), 128'(m_cnt == DEPTH));
    chk("empty",    128'(stqEmpty_o), 128'(m_cnt == 0));
    chk("valid",    128'(dcWrValid_o), 128'(m_busy));
    if (m_busy) chk("payload", 128'({dcWrAddr_o, dcWrData_o, dcWrSize_o}), 128'(m_pl));
    if (m_busy && r && !rs) sends++;

    drained = m_busy && r;
    cok = c && (m_ccnt < m_cnt);
    aok = a && (m_cnt < DEPTH) && !f;
    ncc = m_ccnt + int'(cok) - int'(drained);
    nh  = (m_head + int'(drained)) % DEPTH;
    if (f) begin
      nt = (nh + ncc) % DEPTH;
      nc = ncc;
    end else begin
      nt = (m_tail + int'(aok)) % DEPTH;
      nc = m_cnt + int'(aok) - int'(drained);
    end
    npl = m_pl;
    if (m_busy) nbusy = !r;
    else begin
      nbusy = (m_ccnt > 0) || cok;
      if (nbusy) npl = mem[m_head];
    end
    wr_idx = m_tail;

    @(posedge clk);
    #1;
    if (rs) model_clear();
    else begin
      m_head = nh; m_tail = nt; m_cnt = nc; m_ccnt = ncc; m_busy = nbusy; m_pl = npl;
      if (aok) mem[wr_idx] = rand_entry();
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = rand_entry();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    model_clear();

    // Four allocs, no commits: nothing is sent.
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0, 1);
    repeat (3) cyc(0, 0, 0, 0, 1);
    chk("alloc4_idx", 128'(allocIdx_o), 128'(4));

    // Commit one with ready high: one-cycle latency, one-cycle handshake.
    cyc(0, 0, 1, 0, 1);
    chk("lat1_valid", 128'(dcWrValid_o), 128'(1));
    repeat (3) cyc(0, 0, 0, 0, 1);
    chk("lat1_head", 128'(stqRdAddr_o), 128'(1));

    // Fill to full, overflow alloc, then drain everything across the wrap.
    cyc(1, 0, 0, 0, 0);
    sends = 0;
    for (int i = 0; i < DEPTH + 1; i++) cyc(0, 1, 0, 0, 1);
    chk("full_tail", 128'(allocIdx_o), 128'(0));
    for (int i = 0; i < DEPTH; i++) cyc(0, 0, 1, 0, 1);
    repeat (2 * DEPTH + 4) cyc(0, 0, 0, 0, 1);
    chk("full_sends", 128'(sends), 128'(DEPTH));
    chk("full_empty", 128'(stqEmpty_o), 128'(1));

    // Alloc 5, commit 2, flush; ready held low 5 cycles, then drain.
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 0, 1, 0);
    chk("flush_tail", 128'(allocIdx_o), 128'(2));
    repeat (5) cyc(0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    repeat (6) cyc(0, 0, 0, 0, 1);

    // Reset in the middle of a stalled send.
    cyc(0, 1, 1, 0, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("rst_valid", 128'(dcWrValid_o), 128'(0));

    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(0, 299) == 0, $urandom_range(0, 99) < 60,
          $urandom_range(0, 99) < 40, $urandom_range(0, 99) < 4,
          $urandom_range(0, 99) < 60);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
